hazard_ctrl_mc: RTL
===================

HAZARD_CTRL_MC -- requirements
Module: hazard_ctrl_mc

Interface
REQ-001 Parameter REG_AW, default 5, meaning register-specifier width.
REQ-002 Parameter LOAD_LAT, default 1, legal range 1..4, meaning load-use stall cycles per detected hazard.
REQ-003 Parameter MD_LAT, default 8, legal range 2..32, meaning multiply/divide busy cycles after issue.
REQ-004 Parameter PERF_W, default 16, meaning width of the saturating performance counters.
REQ-005 Port list, one per line:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_ex_dm_r  in  1  EX-stage instruction is a load.
- id_ex_rt_sel  in  REG_AW  load destination register.
- if_id_rs_sel  in  REG_AW  ID-stage rs.
- if_id_rt_sel  in  REG_AW  ID-stage rt.
- if_id_md_use  in  1  ID-stage instruction reads HI/LO or is mul/div.
- ex_md_start  in  1  EX-stage instruction issues mul/div this cycle.
- ex_redirect  in  1  EX resolves jr, j, or taken branch.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID register enable.
- if_id_flush  out  1  IF/ID bubble insert.
- id_ex_flush  out  1  ID/EX bubble insert.
- stall_cause  out  2  0 none, 1 load-use, 2 md-busy, 3 redirect.
- md_busy  out  1  mul/div unit occupied.
- stall_cnt  out  PERF_W  stalled-cycle count.
- flush_cnt  out  PERF_W  redirect count.

Function
REQ-006 Load-use hazard (LU) SHALL be detected when id_ex_dm_r=1, id_ex_rt_sel!=0, and id_ex_rt_sel equals if_id_rs_sel or if_id_rt_sel.
REQ-007 Register 0 SHALL never cause an LU.
REQ-008 Load counter lcnt SHALL be 0 when idle; an LU seen with lcnt=0 and no redirect SHALL load lcnt=LOAD_LAT-1.
REQ-009 Nonzero lcnt SHALL decrement by 1 per cycle; an LU stall SHALL therefore last exactly LOAD_LAT consecutive cycles.
REQ-010 While lcnt!=0, the stall SHALL hold regardless of id_ex_* inputs, which are bubbles.
REQ-011 On ex_md_start, counter mcnt SHALL load MD_LAT, then decrement by 1 per cycle to 0.
REQ-012 md_busy SHALL be 1 exactly when mcnt!=0.
REQ-013 ex_md_start while md_busy=1 SHALL reload mcnt with MD_LAT.
REQ-014 MD stall SHALL be asserted when md_busy=1 and if_id_md_use=1.
REQ-015 Outputs SHALL be combinational from state and inputs, with priority redirect > LU > MD.
REQ-016 Redirect outputs: pc_write=1, if_id_write=0, if_id_flush=1, id_ex_flush=1, stall_cause=3.
REQ-017 LU outputs (LU detected or lcnt!=0): pc_write=0, if_id_write=0, if_id_flush=0, id_ex_flush=1, stall_cause=1.
REQ-018 MD outputs: same as LU, with stall_cause=2.
REQ-019 With no hazard: pc_write=1, if_id_write=1, both flushes 0, stall_cause=0.
REQ-020 ex_redirect SHALL clear lcnt to 0 on the same edge, because the stalled ID instruction is wrong-path.
REQ-021 ex_redirect SHALL NOT alter mcnt; an issued mul/div continues.
REQ-022 stall_cnt SHALL increment on every edge with stall_cause of 1 or 2.
REQ-023 flush_cnt SHALL increment on every edge with stall_cause=3.
REQ-024 Both performance counters SHALL saturate at 2^PERF_W-1 and never wrap.
REQ-025 ex_md_start and an LU in the same cycle SHALL both take effect: mcnt loads and the LU stall proceeds.

Reset
REQ-026 While rst_n=0, lcnt, mcnt, stall_cnt and flush_cnt SHALL be 0 immediately, independent of clk.
REQ-027 While rst_n=0, outputs SHALL be forced to pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1, stall_cause=0, md_busy=0.
REQ-028 Reset asserted mid-stall SHALL abandon the stall; the first cycle after release SHALL show no-hazard outputs given idle inputs.

Verification
REQ-029 LOAD_LAT=1: load to r5 in EX, ID rs=r5 -> one cycle with pc_write=0 and id_ex_flush=1, then normal; stall_cnt=1.
REQ-030 LOAD_LAT=3: same stimulus, held 1 cycle -> 3 consecutive stall cycles, stall_cause=1; stall_cnt=3.
REQ-031 Load to r0 with ID rs=r0 -> no stall; stall_cnt unchanged.
REQ-032 MD_LAT=8: md_start at cycle 0, if_id_md_use=1 from cycle 1 -> stall_cause=2 for cycles 1-8, released at cycle 9.
REQ-033 Redirect in the first of 3 LU-stall cycles -> that cycle flushes (stall_cause=3), next cycle normal, flush_cnt=1, lcnt=0.
REQ-034 PERF_W=4 with a persistent MD stall for 20 cycles -> stall_cnt holds at 15; then assert rst_n=0 mid-stall -> all counters 0 asynchronously.

Source files
------------

// File: rtl/hazard_ctrl_mc.sv
// hazard_ctrl_mc: pipeline hazard controller for load-use, mul/div-busy and redirect stalls/flushes
// Priority is redirect > load-use > mul/div, with saturating perf counters.
module hazard_ctrl_mc #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int MD_LAT   = 8,
  parameter int PERF_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_ex_dm_r,
  input  logic [REG_AW-1:0] id_ex_rt_sel,
  input  logic [REG_AW-1:0] if_id_rs_sel,
  input  logic [REG_AW-1:0] if_id_rt_sel,
  input  logic              if_id_md_use,
  input  logic              ex_md_start,
  input  logic              ex_redirect,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic [1:0]        stall_cause,
  output logic              md_busy,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
);
  localparam int MW = $clog2(MD_LAT + 1);
  logic [1:0]    lcnt;
  logic [MW-1:0] mcnt;
  logic          lu_det, lu, md;
  logic [1:0]    cause;
  assign lu_det = id_ex_dm_r && id_ex_rt_sel != '0 &&
                  (id_ex_rt_sel == if_id_rs_sel || id_ex_rt_sel == if_id_rt_sel);
  // a running load counter keeps the stall regardless of the bubble now in EX
  assign lu    = lu_det || lcnt != 2'd0;
  assign md    = mcnt != '0 && if_id_md_use;
  assign cause = ex_redirect ? 2'd3 : lu ? 2'd1 : md ? 2'd2 : 2'd0;
  assign stall_cause = rst_n ? cause : 2'd0;
  assign pc_write    = rst_n && (cause == 2'd0 || cause == 2'd3);
  assign if_id_write = rst_n && cause == 2'd0;
  assign if_id_flush = !rst_n || cause == 2'd3;
  assign id_ex_flush = !rst_n || cause != 2'd0;
  assign md_busy     = rst_n && mcnt != '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcnt      <= 2'd0;
      mcnt      <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      lcnt <= ex_redirect ? 2'd0 : lcnt != 2'd0 ? lcnt - 2'd1 : lu_det ? 2'(LOAD_LAT - 1) : 2'd0;
      mcnt <= ex_md_start ? MW'(MD_LAT) : mcnt != '0 ? mcnt - MW'(1) : mcnt;
      if ((cause == 2'd1 || cause == 2'd2) && stall_cnt != '1) stall_cnt <= stall_cnt + PERF_W'(1);
      if (cause == 2'd3 && flush_cnt != '1) flush_cnt <= flush_cnt + PERF_W'(1);
    end
  end
endmodule
